// File: rtl/ebr_readback_streamer.sv
// Walks an EBR read port from address 0 and streams each word out as bytes, LSB first, over valid/ready.
// Optional feature macro EBR_READBACK_CSUM_EN appends one XOR checksum byte after the last data byte.
module ebr_readback_streamer #(
  parameter int DATA_W   = 36,
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1,
  parameter int WORDS    = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int NB   = (DATA_W + 7) / 8;
  localparam int SH_W = NB * 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic              LAT_LAST  = (READ_LAT == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
`ifdef EBR_READBACK_CSUM_EN
    S_TRAILER,
`endif
    S_FINISH
  } state_t;

  state_t          state;
  logic [SH_W-1:0] shreg;
  logic [BI_W-1:0] byte_idx;
  logic            lat_cnt;
  logic            accept;
`ifdef EBR_READBACK_CSUM_EN
  logic [7:0]      csum;
`endif

  assign accept   = out_valid && out_ready;
  // The presented byte is always the bottom of the shift register, so out_data is a plain flop output.
  assign out_data = shreg[7:0];

  // NOTE: non-blocking assignments throughout, so every branch below sees pre-edge register values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      shreg     <= '0;
      byte_idx  <= '0;
      lat_cnt   <= 1'b0;
`ifdef EBR_READBACK_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      done   <= 1'b0;
      mem_ce <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr <= '0;
            busy     <= 1'b1;
            mem_ce   <= 1'b1;
`ifdef EBR_READBACK_CSUM_EN
            csum     <= '0;
`endif
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            shreg     <= SH_W'(mem_rdata);
            byte_idx  <= '0;
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end else begin
            lat_cnt <= 1'b1;
          end
        end
        S_EMIT: begin
          if (accept) begin
            shreg <= shreg >> 8;
`ifdef EBR_READBACK_CSUM_EN
            csum  <= csum ^ shreg[7:0];
`endif
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + BI_W'(1);
            end else if (mem_addr != LAST_ADDR) begin
              // Terminate on the index compare so a full 2^ADDR_W dump never wraps the address.
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_ce    <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_ISSUE;
            end else begin
`ifdef EBR_READBACK_CSUM_EN
              shreg <= SH_W'(csum ^ shreg[7:0]);
              state <= S_TRAILER;
`else
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_FINISH;
`endif
            end
          end
        end
`ifdef EBR_READBACK_CSUM_EN
        S_TRAILER: begin
          if (accept) begin
            shreg     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FINISH;
          end
        end
`endif
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebr_readback_streamer.sv
// Randomised self-checking bench for ebr_readback_streamer: a 36-bit/latency-1 and a 9-bit/latency-2 instance
// are compared against a byte-stream model derived from the memory contents.
module tb_ebr_readback_streamer;

`ifdef EBR_READBACK_CSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int A_DW = 36, A_AW = 2, A_RL = 1, A_WORDS = 4;
  localparam int B_DW = 9,  B_AW = 4, B_RL = 2, B_WORDS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        start = '0;
  logic [1:0]        out_ready = '0;
  wire  [1:0]        busy, done, mem_ce, out_valid;
  wire  [7:0]        out_data [2];
  wire  [A_AW-1:0]   a_addr;
  wire  [B_AW-1:0]   b_addr;
  logic [3:0]        mem_addr [2];
  wire  [A_DW-1:0]   a_rdata;
  wire  [B_DW-1:0]   b_rdata;

  assign mem_addr[0] = 4'(a_addr);
  assign mem_addr[1] = b_addr;

  // Behavioural EBR: first stage loads on mem_ce, optional output register clocks freely.
  logic [35:0] mem [2][4];
  logic [35:0] q1 [2];
  logic [35:0] q2 [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_ce[i]) q1[i] <= mem[i][mem_addr[i][1:0]];
      q2[i] <= q1[i];
    end
  end
  assign a_rdata = (A_RL == 1) ? q1[0] : q2[0];
  assign b_rdata = (B_RL == 1) ? q1[1][B_DW-1:0] : q2[1][B_DW-1:0];

  ebr_readback_streamer #(.DATA_W(A_DW), .ADDR_W(A_AW), .READ_LAT(A_RL), .WORDS(A_WORDS)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .mem_ce(mem_ce[0]), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  ebr_readback_streamer #(.DATA_W(B_DW), .ADDR_W(B_AW), .READ_LAT(B_RL), .WORDS(B_WORDS)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .mem_ce(mem_ce[1]), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  function automatic int dw(input int i);    return (i == 0) ? A_DW : B_DW;       endfunction
  function automatic int rl(input int i);    return (i == 0) ? A_RL : B_RL;       endfunction
  function automatic int words(input int i); return (i == 0) ? A_WORDS : B_WORDS; endfunction
  function automatic int nb(input int i);    return (dw(i) + 7) / 8;              endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input longint got_v, input longint exp_v);
    n_cmp++;
    if (got_v != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // Observation records, sampled on the falling edge.
  logic [7:0] got [2][64];
  logic [3:0] ce_addr [2][16];
  int got_n[2], ce_n[2], done_n[2], done_cyc[2], first_ce[2], first_val[2];
  int busy_n[2], stall_err[2], addr_err[2], busy_done[2];
  bit prev_stall[2];
  logic [7:0] prev_data[2];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_ce[i]) begin
          if (ce_n[i] == 0) first_ce[i] = cyc;
          if (ce_n[i] < 16) ce_addr[i][ce_n[i]] = mem_addr[i];
          ce_n[i]++;
        end
        if (int'(mem_addr[i]) >= words(i)) addr_err[i]++;
        if (out_valid[i] && first_val[i] < 0) first_val[i] = cyc;
        if (out_valid[i] && out_ready[i]) begin
          if (got_n[i] < 64) got[i][got_n[i]] = out_data[i];
          got_n[i]++;
        end
        if (prev_stall[i] && (!out_valid[i] || out_data[i] != prev_data[i])) stall_err[i]++;
        prev_stall[i] = out_valid[i] && !out_ready[i];
        prev_data[i]  = out_data[i];
        if (busy[i]) busy_n[i]++;
        if (done[i]) begin
          done_n[i]++;
          done_cyc[i] = cyc;
          if (busy[i]) busy_done[i]++;
        end
      end
    end
  end

  task automatic clear_mon(input int i);
    got_n[i] = 0; ce_n[i] = 0; done_n[i] = 0; done_cyc[i] = -1;
    first_ce[i] = -1; first_val[i] = -1; busy_n[i] = 0;
    stall_err[i] = 0; addr_err[i] = 0; busy_done[i] = 0; prev_stall[i] = 1'b0;
  endtask

  // Reference model: every word masked to DATA_W, split into bytes LSB first, optional XOR trailer.
  logic [7:0] exp_b [64];
  int exp_n;
  task automatic build_exp(input int i);
    logic [7:0]  x;
    logic [35:0] w;
    exp_n = 0;
    x = '0;
    for (int n = 0; n < words(i); n++) begin
      w = mem[i][n] & ((36'd1 << dw(i)) - 36'd1);
      for (int k = 0; k < nb(i); k++) begin
        exp_b[exp_n] = 8'(w >> (8 * k));
        x = x ^ exp_b[exp_n];
        exp_n++;
      end
    end
`ifdef EBR_READBACK_CSUM_EN
    exp_b[exp_n] = x;
    exp_n++;
`endif
  endtask

  // Called at posedge+1; start goes high in the current cycle (t0).
  task automatic run_dump(input int i, input int stall_pct, input int start_len,
                          input int poke, input int tail, output int t0);
    clear_mon(i);
    t0 = cyc;
    start[i] = 1'b1;
    out_ready[i] = ($urandom_range(99) >= stall_pct);
    for (int k = 1; k < 3000; k++) begin
      @(posedge clk); #1;
      start[i] = 1'b0;
      if (done_n[i] > 0) break;
      start[i] = (k < start_len) || (k == poke);
      out_ready[i] = ($urandom_range(99) >= stall_pct);
    end
    repeat (tail) begin @(posedge clk); #1; end
  endtask

  task automatic verify(input int i, input string name, input int t0, input bit timed);
    build_exp(i);
    check({name, "_len"}, got_n[i], exp_n);
    for (int k = 0; k < exp_n && k < got_n[i]; k++)
      check($sformatf("%s_byte%0d", name, k), got[i][k], exp_b[k]);
    check({name, "_done_cnt"}, done_n[i], 1);
    if (timed)
      check({name, "_done_cyc"}, done_cyc[i], t0 + 1 + words(i) * (nb(i) + rl(i) + 1) + CSUM);
    check({name, "_first_ce"}, first_ce[i], t0 + 1);
    check({name, "_first_valid"}, first_val[i], t0 + 2 + rl(i));
    check({name, "_ce_cnt"}, ce_n[i], words(i));
    for (int j = 0; j < ce_n[i] && j < 16; j++)
      check($sformatf("%s_ce_addr%0d", name, j), ce_addr[i][j], j);
    check({name, "_stall_hold"}, stall_err[i], 0);
    check({name, "_addr_range"}, addr_err[i], 0);
    check({name, "_busy_cycles"}, busy_n[i], done_cyc[i] - t0 - 1);
    check({name, "_busy_with_done"}, busy_done[i], 0);
  endtask

  task automatic check_idle_outputs(input int i, input string name);
    check({name, "_busy"}, busy[i], 0);
    check({name, "_done"}, done[i], 0);
    check({name, "_mem_ce"}, mem_ce[i], 0);
    check({name, "_mem_addr"}, mem_addr[i], 0);
    check({name, "_out_valid"}, out_valid[i], 0);
    check({name, "_out_data"}, out_data[i], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [7:0] a_w0 [5];
    logic [7:0] b_fix [6];
    logic [7:0] nostall [64];
    int nostall_n;

    a_w0  = '{8'h20, 8'h43, 8'h65, 8'h87, 8'h09};
    b_fix = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h55, 8'h01};
    clear_mon(0);
    clear_mon(1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs(0, "rst_a");
    check_idle_outputs(1, "rst_b");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fixed 36-bit pattern, no stalls.
    for (int n = 0; n < 4; n++) mem[0][n] = 36'h9_8765_4320 + 36'(n);
    run_dump(0, 0, 1, -1, 4, t0);
    verify(0, "a_fixed", t0, 1'b1);
    for (int k = 0; k < 5; k++) check($sformatf("a_word0_byte%0d", k), got[0][k], a_w0[k]);

    // Fixed 9-bit pattern with output-register latency.
    mem[1][0] = 36'h1FF; mem[1][1] = 36'h000; mem[1][2] = 36'h155; mem[1][3] = 36'h0;
    run_dump(1, 0, 1, -1, 4, t0);
    verify(1, "b_fixed", t0, 1'b1);
    for (int k = 0; k < 6; k++) check($sformatf("b_fixed_const%0d", k), got[1][k], b_fix[k]);
`ifdef EBR_READBACK_CSUM_EN
    check("b_fixed_trailer", got[1][6], 8'hAA);
`endif

    // Random 36-bit content: no-stall run, then 50% stall run on the same memory.
    for (int n = 0; n < 4; n++) mem[0][n] = 36'({$urandom(), $urandom()});
    run_dump(0, 0, 1, -1, 4, t0);
    verify(0, "a_rand", t0, 1'b1);
    nostall_n = got_n[0];
    for (int k = 0; k < 64; k++) nostall[k] = got[0][k];
    run_dump(0, 50, 1, -1, 4, t0);
    verify(0, "a_stall", t0, 1'b0);
    check("a_stall_vs_nostall_len", got_n[0], nostall_n);
    for (int k = 0; k < nostall_n && k < got_n[0]; k++)
      check($sformatf("a_stall_vs_nostall%0d", k), got[0][k], nostall[k]);

    // Random 9-bit content with stalls.
    for (int n = 0; n < 4; n++) mem[1][n] = 36'({$urandom(), $urandom()});
    run_dump(1, 50, 1, -1, 4, t0);
    verify(1, "b_stall", t0, 1'b0);

    // Reset while emitting word 2, then a clean dump from word 0.
    clear_mon(0);
    start[0] = 1'b1;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 200 && got_n[0] < 2 * nb(0) + 1; k++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    check("mid_rst_reached_word2", got_n[0], 2 * nb(0) + 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "mid_rst_a");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("mid_rst_no_done", done_n[0], 0);
    for (int n = 0; n < 4; n++) mem[0][n] = 36'({$urandom(), $urandom()});
    run_dump(0, 0, 1, -1, 4, t0);
    verify(0, "a_after_rst", t0, 1'b1);

    // start held for 10 cycles plus a pulse while busy: one dump only.
    run_dump(0, 0, 10, 15, 40, t0);
    verify(0, "a_start_held", t0, 1'b1);

    // start coinciding with done is ignored.
    run_dump(1, 0, 1, 1 + B_WORDS * (nb(1) + B_RL + 1) + CSUM, 3, t0);
    verify(1, "b_start_on_done", t0, 1'b1);

    // start in the cycle after done is accepted.
    run_dump(1, 0, 1, -1, 0, t0);
    verify(1, "b_chain_first", t0, 1'b1);
    run_dump(1, 0, 1, -1, 4, t0);
    verify(1, "b_chain_second", t0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ebr_readback_streamer.md
# ebr_readback_streamer

Sequential reader that walks one EBR block's read port and streams its contents out as a byte stream with valid/ready handshake. It is the read-side counterpart to the EBR configuration fuzz designs: those program EBR_CORE mode and init content into the bitstream; this block reads the contents back on hardware so decoded INITVAL bits can be checked against silicon. It sits between an EBR_CORE read port and a byte-wide transport such as a UART or JTAG-user FIFO.

## Interface
Parameters:
- DATA_W, 36: EBR read-port data width (1, 2, 4, 9, 18 or 36).
- ADDR_W, 14: EBR read address width.
- READ_LAT, 1: EBR read latency in cycles; 1 without output register, 2 with. Only 1 or 2 are legal.
- WORDS, 512: number of words read per dump, 1..2^ADDR_W.

Ports:
- clk  in  1  single clock; EBR read clock and stream clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump from address 0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte is accepted.
- mem_ce  out  1  EBR read clock enable.
- mem_addr  out  ADDR_W  EBR read address.
- mem_rdata  in  DATA_W  EBR read data.
- out_data  out  8  stream byte.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accept.

## Operation
- States: IDLE, ISSUE, WAIT, EMIT, TRAILER (TRAILER exists only with the macro), FINISH.
- IDLE: start=1 clears the word counter and address, then goes to ISSUE. start is ignored in every other state.
- ISSUE: mem_ce=1 for exactly one cycle with mem_addr equal to the current word index, then goes to WAIT.
- WAIT: counts READ_LAT cycles after ISSUE. In the cycle the data is valid, mem_rdata is captured into a shift register, zero-extended to NB = ceil(DATA_W/8) bytes, then goes to EMIT.
- EMIT: presents bytes least-significant first. The byte index advances only on out_valid && out_ready. After byte NB-1 is accepted:
  - if the word index is not WORDS-1, increment the address and go to ISSUE;
  - otherwise go to TRAILER (macro defined) or FINISH.
- FINISH: done=1 and busy=0 for one cycle, then IDLE.
- Address counter is ADDR_W bits. WORDS = 2^ADDR_W terminates on the index compare, not on address wrap. mem_addr never exceeds WORDS-1.
- mem_ce=0 in every state except ISSUE. At most one read is outstanding.

## Timing
- Reset values: busy=0, done=0, mem_ce=0, mem_addr=0, out_valid=0, out_data=0. State is IDLE.
- Reset asserted mid-dump: everything returns to reset values immediately. No done pulse. Any partial stream is abandoned.
- start at cycle 0 gives mem_ce=1 at cycle 1. The first out_valid comes at cycle 2+READ_LAT.
- Per-word overhead with out_ready held at 1: NB + READ_LAT + 1 cycles.
- Stream rules:
  - while out_valid=1 && out_ready=0, out_data and out_valid hold stable;
  - out_valid never drops without acceptance;
  - out_ready while out_valid=0 has no effect.
- done pulses in the cycle after the final accepted byte. busy falls in the same cycle done rises.
- A start in the same cycle as done is ignored. A start in the following cycle is accepted.

## Configuration
- EBR_READBACK_CSUM_EN defined: after the last data byte, TRAILER emits one byte equal to the XOR of all data bytes in the dump, under the same handshake. done follows acceptance of this byte.
- Undefined: no TRAILER state, no checksum register. done follows the last data byte.

## Test plan
- DATA_W=36, READ_LAT=1, WORDS=4, memory word n = 0x9_8765_4320+n, out_ready=1 -> 20 bytes. Word 0 yields 20 43 65 87 09. done pulses exactly once at the expected cycle.
- DATA_W=9, READ_LAT=2, WORDS=3, data 0x1FF, 0x000, 0x155 -> bytes FF 01 00 00 55 01. mem_ce is asserted exactly 3 times, with addresses 0, 1, 2.
- Random out_ready stalls (50%) on the 36-bit case -> byte sequence identical to the no-stall run; out_data stable during every stall.
- rst pulsed while in EMIT on word 2 -> all outputs 0 next cycle, no done. A new start gives a complete dump beginning with word 0.
- start held high for 10 cycles, and start pulsed while busy -> exactly one dump occurs.
- With EBR_READBACK_CSUM_EN, DATA_W=9, WORDS=2, data 0x0A5, 0x10F -> bytes A5 00 0F 01 then trailer AB. Without the macro the same stimulus ends after 01.
